// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the multi-cycle ALU (alu_mc).
//   - RV funct3 / funct7 encodings for the register-register integer ops
//   - op_e : operation decoded from a funct7/funct3 pair
//   - state_e : alu_mc control FSM states
package alu_pkg;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    typedef enum logic [3:0] {
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_OR,
        OP_XOR,
        OP_SLL,
        OP_SRL,
        OP_SRA,
        OP_SLT,
        OP_SLTU,
        OP_ILLEGAL
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    function automatic logic is_shift_op(input op_e op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_mc_comb.sv
// alu_mc_comb: combinational decode plus the single-cycle ALU ops.
// Ports:
//   funct3, funct7 : RV encoding of the requested operation
//   rs1, rs2       : operands (XLEN bits)
//   op             : decoded operation (OP_ILLEGAL for unsupported pairs)
//   res            : result of add/sub, logic and compare ops; 0 for shifts
//                    and illegal ops (shifts are produced by alu_mc)
module alu_mc_comb
    import alu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output op_e             op,
    output logic [XLEN-1:0] res
);

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        op = OP_ILLEGAL;
        if (funct7 == F7_BASE) begin
            case (funct3)
                F3_ADD_SUB: op = OP_ADD;
                F3_SLL:     op = OP_SLL;
                F3_SLT:     op = OP_SLT;
                F3_SLTU:    op = OP_SLTU;
                F3_XOR:     op = OP_XOR;
                F3_SR:      op = OP_SRL;
                F3_OR:      op = OP_OR;
                F3_AND:     op = OP_AND;
                default:    op = OP_ILLEGAL;
            endcase
        end else if (funct7 == F7_ALT) begin
            case (funct3)
                F3_ADD_SUB: op = OP_SUB;
                F3_SR:      op = OP_SRA;
                default:    op = OP_ILLEGAL;
            endcase
        end
    end

    always_comb begin
        res = '0;
        case (op)
            OP_ADD:  res = rs1 + rs2;
            OP_SUB:  res = rs1 - rs2;
            OP_AND:  res = rs1 & rs2;
            OP_OR:   res = rs1 | rs2;
            OP_XOR:  res = rs1 ^ rs2;
            // True signed compare, so overflow of rs1-rs2 cannot flip the answer.
            OP_SLT:  res = {{(XLEN-1){1'b0}}, ($signed(rs1) < $signed(rs2))};
            OP_SLTU: res = {{(XLEN-1){1'b0}}, (rs1 < rs2)};
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: handshaked multi-cycle RV integer ALU (ADD SUB AND OR XOR SLL SRL
// SRA SLT SLTU) at width XLEN (32 or 64).
// Ports:
//   clk, rst            : rising-edge clock, synchronous active-high reset
//   in_valid / in_ready : request handshake; operands sampled on accept only
//   in_funct3/in_funct7 : RV encoding; in_rs1/in_rs2 operands
//   out_valid/out_ready : result handshake; out_rd result, out_illegal flag
// Build option ALU_BARREL_SHIFT_EN: shifts use a one-cycle barrel shifter and
// the SHIFT state/counter are not built. Otherwise shifts iterate one bit per
// cycle. Results are identical in both builds; only latency differs.
module alu_mc
    import alu_pkg::*;
#(
    parameter int XLEN = 64,
    localparam int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_funct3,
    input  logic [6:0]      in_funct7,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_rd,
    output logic            out_illegal
);

    state_e             state;
    op_e                dec_op;
    logic [XLEN-1:0]    dec_res;
    logic [SHAMT_W-1:0] shamt;
    logic               is_shift;

    alu_mc_comb #(.XLEN(XLEN)) u_comb (
        .funct3 (in_funct3),
        .funct7 (in_funct7),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .op     (dec_op),
        .res    (dec_res)
    );

    assign shamt    = in_rs2[SHAMT_W-1:0];
    assign is_shift = is_shift_op(dec_op);
    // No result bypass: a new request is only taken from IDLE.
    assign in_ready = (state == IDLE);

`ifdef ALU_BARREL_SHIFT_EN
    function automatic logic [XLEN-1:0] shift_full(input op_e op,
                                                   input logic [XLEN-1:0] v,
                                                   input logic [SHAMT_W-1:0] amt);
        case (op)
            OP_SLL:  return v << amt;
            OP_SRL:  return v >> amt;
            OP_SRA:  return $signed(v) >>> amt;
            default: return v;
        endcase
    endfunction
`else
    logic [XLEN-1:0]    shift_q;
    logic [SHAMT_W-1:0] shift_cnt;
    op_e                shift_op;

    function automatic logic [XLEN-1:0] shift1(input op_e op,
                                               input logic [XLEN-1:0] v);
        case (op)
            OP_SLL:  return {v[XLEN-2:0], 1'b0};
            OP_SRL:  return {1'b0, v[XLEN-1:1]};
            OP_SRA:  return {v[XLEN-1], v[XLEN-1:1]};
            default: return v;
        endcase
    endfunction
`endif

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            out_rd      <= '0;
            out_illegal <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
            shift_q     <= '0;
            shift_cnt   <= '0;
            shift_op    <= OP_ADD;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        out_illegal <= (dec_op == OP_ILLEGAL);
`ifdef ALU_BARREL_SHIFT_EN
                        out_rd    <= is_shift ? shift_full(dec_op, in_rs1, shamt) : dec_res;
                        out_valid <= 1'b1;
                        state     <= DONE;
`else
                        if (is_shift && (shamt != '0)) begin
                            shift_q   <= in_rs1;
                            shift_cnt <= shamt;
                            shift_op  <= dec_op;
                            state     <= SHIFT;
                        end else begin
                            // A zero-distance shift returns rs1 unchanged.
                            out_rd    <= is_shift ? in_rs1 : dec_res;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
`endif
                    end
                end
`ifndef ALU_BARREL_SHIFT_EN
                SHIFT: begin
                    // The last step writes straight into out_rd so the result
                    // is ready on the edge that raises out_valid.
                    if (shift_cnt == SHAMT_W'(1)) begin
                        out_rd    <= shift1(shift_op, shift_q);
                        out_valid <= 1'b1;
                        shift_cnt <= '0;
                        state     <= DONE;
                    end else begin
                        shift_q   <= shift1(shift_op, shift_q);
                        shift_cnt <= shift_cnt - SHAMT_W'(1);
                    end
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
